score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter WIN_SCORE, default 7, points needed to win a match (legal range 1..15).
REQ-002 Parameter SERVE_FRAMES, default 30, frameTicks of hold-off before each serve (legal range 1..255).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-high.
REQ-005 start  input  1  level from start button; rising edge starts or restarts a match.
REQ-006 frameTick  input  1  one-cycle pulse per video frame.
REQ-007 lhs_scored  input  1  level from ball controller; held high while the left player's goal event persists.
REQ-008 rhs_scored  input  1  level from ball controller; held high while the right player's goal event persists.
REQ-009 done_blackScreen  input  1  from ball renderer; high once the full-screen clear has completed.
REQ-010 play_enable  output  1  enable to ball physics, ball controller and renderer.
REQ-011 blackScreen_pulse  output  1  request for a full-screen clear and ball re-centre.
REQ-012 lhs_score  output  4  left player's score.
REQ-013 rhs_score  output  4  right player's score.
REQ-014 game_over  output  1  high while a match is won and not yet restarted.
REQ-015 winner  output  1  0 = left, 1 = right; valid only while game_over is high.

Function
REQ-016 FSM states: S_IDLE, S_CLEAR, S_SERVE, S_PLAY, S_OVER; encoding is free.
REQ-017 Edge detection: start, lhs_scored and rhs_scored are each registered every cycle; an event is input high AND previous-cycle sample low.
REQ-018 S_IDLE: play_enable=0; start edge -> clear both scores, go to S_CLEAR.
REQ-019 S_CLEAR: blackScreen_pulse=1 on every cycle in this state; done_blackScreen=1 -> S_SERVE next cycle.
REQ-020 S_SERVE: play_enable=0; on entry, load the serve counter with SERVE_FRAMES; decrement on each frameTick; on the frameTick that brings it to 0 -> S_PLAY.
REQ-021 S_PLAY: play_enable=1; a lhs_scored edge increments lhs_score; a rhs_scored edge increments rhs_score.
REQ-022 Simultaneous lhs and rhs edges in one cycle: only the left increment is applied; the right event is discarded.
REQ-023 After a score increment: if the new score equals WIN_SCORE -> S_OVER, with winner set to the scoring side; otherwise -> S_CLEAR.
REQ-024 Score edges arriving outside S_PLAY have no effect, including a level still high when S_PLAY is entered.
REQ-025 S_OVER: game_over=1, play_enable=0, scores held; start edge -> clear scores, clear game_over, go to S_CLEAR.
REQ-026 A start edge in S_CLEAR, S_SERVE or S_PLAY is ignored.
REQ-027 Score increment happens on the same clock edge as the FSM transition; latency from the scored-input rising edge to the updated score output is 1 cycle.
REQ-028 play_enable falls on the same edge on which the score updates.
REQ-029 Scores never exceed WIN_SCORE; there is no wrap-around.

Reset
REQ-030 While reset=1 the block enters S_IDLE immediately, independent of clk.
REQ-031 Reset values: lhs_score=0, rhs_score=0, play_enable=0, blackScreen_pulse=0, game_over=0, winner=0, serve counter=0, all edge-detect registers=0.
REQ-032 Reset asserted mid-clear or mid-serve abandons the operation; no partial score or state is retained.

Configuration
REQ-033 Macro SCORE_KEEPER_SERVE_DELAY_EN.
REQ-034 When SCORE_KEEPER_SERVE_DELAY_EN is defined: S_SERVE behaves as in REQ-020.
REQ-035 When SCORE_KEEPER_SERVE_DELAY_EN is undefined: S_SERVE lasts exactly one cycle and then goes to S_PLAY, with no serve counter implemented; SERVE_FRAMES is ignored.

Verification
REQ-036 Reset, then a start edge -> blackScreen_pulse=1 from the next cycle; assert done_blackScreen -> after 30 frameTicks play_enable=1 (macro defined).
REQ-037 In S_PLAY, hold lhs_scored high for 5 cycles -> lhs_score increments exactly once, 0->1; play_enable=0 one cycle after the rising edge; blackScreen_pulse=1.
REQ-038 Raise lhs_scored and rhs_scored on the same cycle -> lhs_score+1, rhs_score unchanged.
REQ-039 With WIN_SCORE=3, right scores 3 times -> rhs_score=3, game_over=1, winner=1; a further rhs_scored edge leaves the score at 3; a start edge -> both scores=0, game_over=0, blackScreen_pulse=1.
REQ-040 Assert reset asynchronously mid-S_SERVE with lhs_score=2 -> all outputs return to reset values before the next clk edge; the block stays in S_IDLE until a start edge.
REQ-041 Macro undefined: done_blackScreen asserted -> play_enable=1 exactly 2 cycles later, with no frameTick required.

Source files
------------

// File: rtl/score_keeper.sv
// Match scoring FSM: clear -> serve hold-off -> play -> score/win.
// Optional serve countdown enabled by SCORE_KEEPER_SERVE_DELAY_EN.
module score_keeper #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       frameTick,
    input  logic       lhs_scored,
    input  logic       rhs_scored,
    input  logic       done_blackScreen,
    output logic       play_enable,
    output logic       blackScreen_pulse,
    output logic [3:0] lhs_score,
    output logic [3:0] rhs_score,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SERVE,
        S_PLAY,
        S_OVER
    } state_t;

    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    state_t     state;
    logic       start_q;
    logic       lhs_q;
    logic       rhs_q;
    logic       start_ev;
    logic       lhs_ev;
    logic       rhs_ev;
    logic [3:0] lhs_next;
    logic [3:0] rhs_next;

`ifdef SCORE_KEEPER_SERVE_DELAY_EN
    localparam logic [7:0] SERVE_LD = 8'(SERVE_FRAMES);
    logic [7:0] serve_cnt;
`else
    logic unused_serve;
    assign unused_serve = frameTick ^ (SERVE_FRAMES == 0);
`endif

    assign start_ev = start & ~start_q;
    assign lhs_ev   = lhs_scored & ~lhs_q;
    assign rhs_ev   = rhs_scored & ~rhs_q;
    assign lhs_next = lhs_score + 4'd1;
    assign rhs_next = rhs_score + 4'd1;

    // Previous-cycle samples for rising-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q <= 1'b0;
            lhs_q   <= 1'b0;
            rhs_q   <= 1'b0;
        end else begin
            start_q <= start;
            lhs_q   <= lhs_scored;
            rhs_q   <= rhs_scored;
        end
    end

    // Match FSM with registered outputs and score counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= S_IDLE;
            play_enable       <= 1'b0;
            blackScreen_pulse <= 1'b0;
            lhs_score         <= 4'd0;
            rhs_score         <= 4'd0;
            game_over         <= 1'b0;
            winner            <= 1'b0;
`ifdef SCORE_KEEPER_SERVE_DELAY_EN
            serve_cnt         <= 8'd0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start_ev) begin
                        lhs_score         <= 4'd0;
                        rhs_score         <= 4'd0;
                        blackScreen_pulse <= 1'b1;
                        state             <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (done_blackScreen) begin
                        blackScreen_pulse <= 1'b0;
                        state             <= S_SERVE;
`ifdef SCORE_KEEPER_SERVE_DELAY_EN
                        serve_cnt         <= SERVE_LD;
`endif
                    end
                end
                S_SERVE: begin
`ifdef SCORE_KEEPER_SERVE_DELAY_EN
                    if (frameTick) begin
                        serve_cnt <= serve_cnt - 8'd1;
                        if (serve_cnt == 8'd1) begin
                            play_enable <= 1'b1;
                            state       <= S_PLAY;
                        end
                    end
`else
                    play_enable <= 1'b1;
                    state       <= S_PLAY;
`endif
                end
                S_PLAY: begin
                    // Left wins a tie; the simultaneous right edge is dropped
                    if (lhs_ev) begin
                        lhs_score   <= lhs_next;
                        play_enable <= 1'b0;
                        if (lhs_next == WIN) begin
                            game_over <= 1'b1;
                            winner    <= 1'b0;
                            state     <= S_OVER;
                        end else begin
                            blackScreen_pulse <= 1'b1;
                            state             <= S_CLEAR;
                        end
                    end else if (rhs_ev) begin
                        rhs_score   <= rhs_next;
                        play_enable <= 1'b0;
                        if (rhs_next == WIN) begin
                            game_over <= 1'b1;
                            winner    <= 1'b1;
                            state     <= S_OVER;
                        end else begin
                            blackScreen_pulse <= 1'b1;
                            state             <= S_CLEAR;
                        end
                    end
                end
                S_OVER: begin
                    if (start_ev) begin
                        lhs_score         <= 4'd0;
                        rhs_score         <= 4'd0;
                        game_over         <= 1'b0;
                        blackScreen_pulse <= 1'b1;
                        state             <= S_CLEAR;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper with a score/match model.
// Serve timing follows SCORE_KEEPER_SERVE_DELAY_EN when defined.
module tb_score_keeper;

    localparam int WIN = 3;
    localparam int SF  = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       frameTick = 1'b0;
    logic       lhs_scored = 1'b0;
    logic       rhs_scored = 1'b0;
    logic       done_blackScreen = 1'b0;
    logic       play_enable;
    logic       blackScreen_pulse;
    logic [3:0] lhs_score;
    logic [3:0] rhs_score;
    logic       game_over;
    logic       winner;

    int n_checks = 0;
    int n_fail   = 0;
    int m_l      = 0;
    int m_r      = 0;

    score_keeper #(
        .WIN_SCORE   (WIN),
        .SERVE_FRAMES(SF)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .frameTick        (frameTick),
        .lhs_scored       (lhs_scored),
        .rhs_scored       (rhs_scored),
        .done_blackScreen (done_blackScreen),
        .play_enable      (play_enable),
        .blackScreen_pulse(blackScreen_pulse),
        .lhs_score        (lhs_score),
        .rhs_score        (rhs_score),
        .game_over        (game_over),
        .winner           (winner)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] outs();
        return {play_enable, blackScreen_pulse, lhs_score, rhs_score,
                game_over, winner};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    // Acknowledge the clear and run the serve until play resumes
    task automatic go_play(output bit to, output int lat, output int ticks);
        int k;
        to = 1'b0;
        lat = 0;
        ticks = 0;
        k = 0;
        while (blackScreen_pulse !== 1'b1 && k < 20) begin
            cyc(1);
            k++;
        end
        if (blackScreen_pulse !== 1'b1) to = 1'b1;
        done_blackScreen = 1'b1;
        cyc(1);
        done_blackScreen = 1'b0;
        while (play_enable !== 1'b1 && lat < 400) begin
`ifdef SCORE_KEEPER_SERVE_DELAY_EN
            frameTick = (lat % 2 == 0);
            if (frameTick) ticks++;
`endif
            cyc(1);
            frameTick = 1'b0;
            lat++;
        end
        if (play_enable !== 1'b1) to = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(2);
        n_checks++;
        if (outs() !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_values: got %h want 000", outs());
        end
        reset = 1'b0;
        done_blackScreen = 1'b1;
        frameTick = 1'b1;
        cyc(4);
        done_blackScreen = 1'b0;
        frameTick = 1'b0;
        n_checks++;
        if (outs() !== 12'd0) begin
            n_fail++;
            $display("FAIL idle_hold: got %h want 000", outs());
        end
    endtask

    task automatic test_start();
        bit to;
        int lat;
        int ticks;
        pulse_start();
        n_checks++;
        if ({play_enable, blackScreen_pulse} !== 2'b01) begin
            n_fail++;
            $display("FAIL start_clear: got %b want 01",
                     {play_enable, blackScreen_pulse});
        end
        cyc(3);
        n_checks++;
        if (blackScreen_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_persist: got %b want 1", blackScreen_pulse);
        end
        go_play(to, lat, ticks);
        n_checks++;
        if (to !== 1'b0) begin
            n_fail++;
            $display("FAIL start_timeout: got %b want 0", to);
        end
`ifdef SCORE_KEEPER_SERVE_DELAY_EN
        n_checks++;
        if (ticks != SF) begin
            n_fail++;
            $display("FAIL serve_ticks: got %0d want %0d", ticks, SF);
        end
`else
        n_checks++;
        if (lat != 1) begin
            n_fail++;
            $display("FAIL serve_latency: got %0d want 1", lat);
        end
`endif
        n_checks++;
        if ({play_enable, blackScreen_pulse} !== 2'b10) begin
            n_fail++;
            $display("FAIL play_entry: got %b want 10",
                     {play_enable, blackScreen_pulse});
        end
    endtask

    task automatic test_hold();
        lhs_scored = 1'b1;
        cyc(1);
        m_l++;
        n_checks++;
        if (lhs_score !== 4'(m_l)) begin
            n_fail++;
            $display("FAIL hold_inc: got %0d want %0d", lhs_score, m_l);
        end
        n_checks++;
        if ({play_enable, blackScreen_pulse} !== 2'b01) begin
            n_fail++;
            $display("FAIL hold_stop: got %b want 01",
                     {play_enable, blackScreen_pulse});
        end
        cyc(4);
        n_checks++;
        if (lhs_score !== 4'(m_l)) begin
            n_fail++;
            $display("FAIL hold_once: got %0d want %0d", lhs_score, m_l);
        end
        lhs_scored = 1'b0;
        cyc(1);
    endtask

    task automatic test_outside();
        bit to;
        int lat;
        int ticks;
        rhs_scored = 1'b1;
        cyc(2);
        go_play(to, lat, ticks);
        n_checks++;
        if (to !== 1'b0) begin
            n_fail++;
            $display("FAIL outside_timeout: got %b want 0", to);
        end
        cyc(2);
        n_checks++;
        if ({play_enable, rhs_score} !== {1'b1, 4'(m_r)}) begin
            n_fail++;
            $display("FAIL outside_level: got %h want %h",
                     {play_enable, rhs_score}, {1'b1, 4'(m_r)});
        end
        rhs_scored = 1'b0;
        cyc(1);
        n_checks++;
        if ({play_enable, rhs_score} !== {1'b1, 4'(m_r)}) begin
            n_fail++;
            $display("FAIL outside_fall: got %h want %h",
                     {play_enable, rhs_score}, {1'b1, 4'(m_r)});
        end
    endtask

    task automatic test_simul();
        pulse_start();
        cyc(1);
        n_checks++;
        if ({play_enable, blackScreen_pulse} !== 2'b10) begin
            n_fail++;
            $display("FAIL start_in_play: got %b want 10",
                     {play_enable, blackScreen_pulse});
        end
        lhs_scored = 1'b1;
        rhs_scored = 1'b1;
        cyc(1);
        m_l++;
        n_checks++;
        if ({lhs_score, rhs_score} !== {4'(m_l), 4'(m_r)}) begin
            n_fail++;
            $display("FAIL simul: got %h want %h",
                     {lhs_score, rhs_score}, {4'(m_l), 4'(m_r)});
        end
        lhs_scored = 1'b0;
        rhs_scored = 1'b0;
        cyc(2);
        n_checks++;
        if (rhs_score !== 4'(m_r)) begin
            n_fail++;
            $display("FAIL simul_drop: got %0d want %0d", rhs_score, m_r);
        end
    endtask

    task automatic test_reset_mid_serve();
        done_blackScreen = 1'b1;
        cyc(1);
        done_blackScreen = 1'b0;
        n_checks++;
        if (lhs_score !== 4'(m_l)) begin
            n_fail++;
            $display("FAIL pre_reset_score: got %0d want %0d", lhs_score, m_l);
        end
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if (outs() !== 12'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h want 000", outs());
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_l = 0;
        m_r = 0;
        repeat (10) begin
            done_blackScreen = 1'($urandom);
            frameTick = 1'($urandom);
            cyc(1);
        end
        done_blackScreen = 1'b0;
        frameTick = 1'b0;
        n_checks++;
        if (outs() !== 12'd0) begin
            n_fail++;
            $display("FAIL stay_idle: got %h want 000", outs());
        end
        pulse_start();
        n_checks++;
        if (blackScreen_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_after_reset: got %b want 1",
                     blackScreen_pulse);
        end
    endtask

    task automatic test_right_win();
        bit to;
        int lat;
        int ticks;
        for (int i = 1; i <= WIN; i++) begin
            go_play(to, lat, ticks);
            n_checks++;
            if (to !== 1'b0) begin
                n_fail++;
                $display("FAIL right_timeout: got %b want 0", to);
            end
            rhs_scored = 1'b1;
            cyc(1);
            m_r++;
            n_checks++;
            if (rhs_score !== 4'(m_r)) begin
                n_fail++;
                $display("FAIL right_point: got %0d want %0d", rhs_score, m_r);
            end
            rhs_scored = 1'b0;
            cyc(1);
        end
        n_checks++;
        if ({game_over, winner, play_enable} !== 3'b110) begin
            n_fail++;
            $display("FAIL right_win: got %b want 110",
                     {game_over, winner, play_enable});
        end
        rhs_scored = 1'b1;
        cyc(1);
        rhs_scored = 1'b0;
        cyc(1);
        n_checks++;
        if ({game_over, rhs_score} !== {1'b1, 4'(WIN)}) begin
            n_fail++;
            $display("FAIL no_overflow: got %h want %h",
                     {game_over, rhs_score}, {1'b1, 4'(WIN)});
        end
        pulse_start();
        m_r = 0;
        n_checks++;
        if ({lhs_score, rhs_score, game_over, blackScreen_pulse} !== 10'b1) begin
            n_fail++;
            $display("FAIL restart: got %h want 001",
                     {lhs_score, rhs_score, game_over, blackScreen_pulse});
        end
    endtask

    task automatic test_random();
        bit to;
        int lat;
        int ticks;
        int side;
        bit over;
        bit win;
        for (int p = 0; p < 40; p++) begin
            go_play(to, lat, ticks);
            n_checks++;
            if (to !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_timeout: got %b want 0", to);
            end
            cyc($urandom_range(0, 3));
            side = $urandom_range(0, 3);
            lhs_scored = (side != 1);
            rhs_scored = (side == 1 || side == 2);
            cyc(1);
            if (side != 1) m_l++;
            else m_r++;
            over = (m_l == WIN) || (m_r == WIN);
            win = (m_r == WIN);
            n_checks++;
            if ({lhs_score, rhs_score} !== {4'(m_l), 4'(m_r)}) begin
                n_fail++;
                $display("FAIL rand_score: got %h want %h",
                         {lhs_score, rhs_score}, {4'(m_l), 4'(m_r)});
            end
            n_checks++;
            if ({play_enable, game_over} !== {1'b0, over}) begin
                n_fail++;
                $display("FAIL rand_state: got %b want %b",
                         {play_enable, game_over}, {1'b0, over});
            end
            if (over) begin
                n_checks++;
                if (winner !== win) begin
                    n_fail++;
                    $display("FAIL rand_winner: got %b want %b", winner, win);
                end
            end
            cyc($urandom_range(0, 3));
            n_checks++;
            if ({lhs_score, rhs_score} !== {4'(m_l), 4'(m_r)}) begin
                n_fail++;
                $display("FAIL rand_hold: got %h want %h",
                         {lhs_score, rhs_score}, {4'(m_l), 4'(m_r)});
            end
            lhs_scored = 1'b0;
            rhs_scored = 1'b0;
            cyc(1);
            if (over) begin
                pulse_start();
                m_l = 0;
                m_r = 0;
                n_checks++;
                if ({lhs_score, rhs_score, game_over} !== 9'd0) begin
                    n_fail++;
                    $display("FAIL rand_restart: got %h want 000",
                             {lhs_score, rhs_score, game_over});
                end
            end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_start();
        test_hold();
        test_outside();
        test_simul();
        test_reset_mid_serve();
        test_right_win();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
